// File: rtl/mole_draw_scheduler.sv
// Arbitrates the shared vga_adapter pixel port among three mole slots and scans one box per grant.
// Optional full-screen clear on game start / reset release: define MOLE_DRAW_CLEAR_EN.
module mole_draw_scheduler #(
    parameter int         BOX_W      = 8,
    parameter int         BOX_H      = 8,
    parameter int         X0         = 1,
    parameter int         X_STEP     = 8,
    parameter int         Y_TOP      = 33,
    parameter int         SCREEN_W   = 160,
    parameter int         SCREEN_H   = 120,
    parameter logic [2:0] ON_COLOUR  = 3'b100,
    parameter logic [2:0] OFF_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       game,
    input  logic [2:0] mole,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic [2:0] drawn
);
    // state   | meaning
    // S_IDLE  | no plotting; arbitrate clear request, then pending slots
    // S_DRAW  | scanning the granted slot's box with the latched colour
    // S_CLEAR | scanning the whole screen with OFF_COLOUR

`ifdef MOLE_DRAW_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAW = 2'd1, S_CLEAR = 2'd2} state_t;
`else
    localparam bit CLEAR_EN = 1'b0;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAW = 2'd1} state_t;
`endif

    localparam int CW  = (CLEAR_EN && SCREEN_W > BOX_W) ? SCREEN_W : BOX_W;
    localparam int CH  = (CLEAR_EN && SCREEN_H > BOX_H) ? SCREEN_H : BOX_H;
    localparam int PXW = (CW > 1) ? $clog2(CW) : 1;
    localparam int PYW = (CH > 1) ? $clog2(CH) : 1;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic             val_q, val_d;
    logic [1:0]       last_q, last_d;
    logic [PXW-1:0]   px_q, px_d;
    logic [PYW-1:0]   py_q, py_d;
    logic [7:0]       x_q, x_d;
    logic [6:0]       y_q, y_d;
    logic [2:0]       col_q, col_d;
    logic             plot_q, plot_d;
    logic [2:0]       drawn_q, drawn_d;

    logic [2:0]       target, pending;
    logic [1:0]       cand1, cand2, grant;
    logic             box_px_last, box_py_last;

`ifdef MOLE_DRAW_CLEAR_EN
    logic             game_prev_q, game_prev_d;
    logic             clear_req_q, clear_req_d;
    logic             scr_px_last, scr_py_last;
`endif

    always_comb begin
        target  = mole & {3{game}};
        pending = target ^ drawn_q;
        cand1   = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        cand2   = (cand1 == 2'd2) ? 2'd0 : cand1 + 2'd1;
        grant   = pending[cand1] ? cand1 : (pending[cand2] ? cand2 : last_q);

        box_px_last = (px_q == PXW'(BOX_W - 1));
        box_py_last = (py_q == PYW'(BOX_H - 1));

        state_d = state_q;
        slot_d  = slot_q;
        val_d   = val_q;
        last_d  = last_q;
        px_d    = px_q;
        py_d    = py_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        plot_d  = 1'b0;
        drawn_d = drawn_q;

`ifdef MOLE_DRAW_CLEAR_EN
        scr_px_last = (px_q == PXW'(SCREEN_W - 1));
        scr_py_last = (py_q == PYW'(SCREEN_H - 1));
        game_prev_d = game;
        // a rising game edge is remembered until IDLE can act on it
        clear_req_d = clear_req_q | (game & ~game_prev_q);
`endif

        case (state_q)
            S_IDLE: begin
`ifdef MOLE_DRAW_CLEAR_EN
                if (clear_req_d) begin
                    clear_req_d = 1'b0;
                    state_d     = S_CLEAR;
                    px_d        = '0;
                    py_d        = '0;
                    x_d         = 8'd0;
                    y_d         = 7'd0;
                    col_d       = OFF_COLOUR;
                    plot_d      = 1'b1;
                end else
`endif
                if (|pending) begin
                    slot_d  = grant;
                    val_d   = target[grant];
                    last_d  = grant;
                    state_d = S_DRAW;
                    px_d    = '0;
                    py_d    = '0;
                    x_d     = 8'(X0 + int'(grant) * X_STEP);
                    y_d     = 7'(Y_TOP);
                    col_d   = target[grant] ? ON_COLOUR : OFF_COLOUR;
                    plot_d  = 1'b1;
                end
            end
            S_DRAW: begin
                if (box_px_last && box_py_last) begin
                    state_d          = S_IDLE;
                    drawn_d[slot_q]  = val_q;
                end else begin
                    if (box_px_last) begin
                        px_d = '0;
                        py_d = py_q + 1'b1;
                    end else begin
                        px_d = px_q + 1'b1;
                    end
                    x_d    = 8'(X0 + int'(slot_q) * X_STEP + int'(px_d));
                    y_d    = 7'(Y_TOP + int'(py_d));
                    plot_d = 1'b1;
                end
            end
`ifdef MOLE_DRAW_CLEAR_EN
            S_CLEAR: begin
                if (scr_px_last && scr_py_last) begin
                    state_d = S_IDLE;
                    drawn_d = 3'b000;
                end else begin
                    if (scr_px_last) begin
                        px_d = '0;
                        py_d = py_q + 1'b1;
                    end else begin
                        px_d = px_q + 1'b1;
                    end
                    x_d    = 8'(px_d);
                    y_d    = 7'(py_d);
                    plot_d = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            slot_q      <= 2'd0;
            val_q       <= 1'b0;
            last_q      <= 2'd2;
            px_q        <= '0;
            py_q        <= '0;
            x_q         <= 8'd0;
            y_q         <= 7'd0;
            col_q       <= 3'd0;
            plot_q      <= 1'b0;
            drawn_q     <= 3'b000;
`ifdef MOLE_DRAW_CLEAR_EN
            // held high so a game already on at reset doesn't queue a second clear
            game_prev_q <= 1'b1;
            clear_req_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            val_q       <= val_d;
            last_q      <= last_d;
            px_q        <= px_d;
            py_q        <= py_d;
            x_q         <= x_d;
            y_q         <= y_d;
            col_q       <= col_d;
            plot_q      <= plot_d;
            drawn_q     <= drawn_d;
`ifdef MOLE_DRAW_CLEAR_EN
            game_prev_q <= game_prev_d;
            clear_req_q <= clear_req_d;
`endif
        end
    end

    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = col_q;
    assign vga_plot   = plot_q;
    assign busy       = plot_q;
    assign drawn      = drawn_q;

endmodule

// File: tb/tb_mole_draw_scheduler.sv
// Directed bench for mole_draw_scheduler: box scans, round-robin order, mid-draw changes, reset.
module tb_mole_draw_scheduler;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       game = 1'b0;
    logic [2:0] mole = 3'b000;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic [2:0] drawn;

    int checks = 0;
    int errors = 0;

    mole_draw_scheduler dut (
        .clock      (clock),
        .resetn     (resetn),
        .game       (game),
        .mole       (mole),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .drawn      (drawn)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        step;
        step;
        check_eq("reset_out", {vga_x, vga_y, vga_colour, vga_plot, busy, drawn}, 32'd0);
        resetn = 1'b1;
    endtask

    task automatic expect_idle(input int cycles);
        int cnt = 0;
        repeat (cycles) begin
            step;
            if (vga_plot || busy) cnt++;
        end
        check_eq("idle_plots", cnt, 0);
    endtask

    // Waits for the grant, checks every pixel of one box, then the return to idle.
    task automatic expect_box(input int slot, input bit val, input logic [2:0] exp_drawn,
                              input bit toggle);
        int n = 0;
        int idx = 0;
        while (!vga_plot && n < 20) begin
            step;
            n++;
        end
        check_eq("grant_latency", n, 1);
        for (int py = 0; py < 8; py++) begin
            for (int px = 0; px < 8; px++) begin
                check_eq("pixel", {vga_x, vga_y, vga_colour, vga_plot, busy},
                         {8'(1 + slot * 8 + px), 7'(33 + py), (val ? 3'b100 : 3'b000), 2'b11});
                if (toggle && idx == 10) mole = 3'b011;
                if (toggle && idx == 15) mole = 3'b001;
                idx++;
                step;
            end
        end
        check_eq("box_end", {vga_plot, busy}, 2'b00);
        check_eq("drawn", drawn, exp_drawn);
    endtask

`ifdef MOLE_DRAW_CLEAR_EN
    task automatic expect_clear;
        int n = 0;
        int cnt = 0;
        int bad = 0;
        while (!vga_plot && n < 20) begin
            step;
            n++;
        end
        check_eq("clear_latency", n, 1);
        while (vga_plot && cnt < 20000) begin
            if ({vga_x, vga_y, vga_colour, busy} !== {8'(cnt % 160), 7'(cnt / 160), 3'b000, 1'b1})
                bad++;
            cnt++;
            step;
        end
        check_eq("clear_count", cnt, 19200);
        check_eq("clear_pixels_bad", bad, 0);
        check_eq("clear_drawn", drawn, 3'b000);
    endtask
`endif

    initial begin
`ifdef MOLE_DRAW_CLEAR_EN
        game = 1'b1;
        mole = 3'b000;
        do_reset;
        expect_clear;
        expect_idle(5);
        game = 1'b0;
        mole = 3'b100;
        expect_idle(5);
        game = 1'b1;
        expect_clear;
        expect_box(2, 1'b1, 3'b100, 1'b0);
        expect_idle(10);
`else
        // idle with nothing requested
        game = 1'b1;
        mole = 3'b000;
        do_reset;
        expect_idle(100);
        check_eq("idle_drawn", drawn, 3'b000);

        // show slot 0; slot 1 blips on and off mid-draw and must not be drawn
        mole = 3'b001;
        expect_box(0, 1'b1, 3'b001, 1'b1);
        expect_idle(20);
        check_eq("after_blip_drawn", drawn, 3'b001);

        // hide slot 0
        mole = 3'b000;
        expect_box(0, 1'b0, 3'b000, 1'b0);
        expect_idle(5);

        // all three at once from a fresh pointer: served 0,1,2 with one-cycle gaps
        do_reset;
        mole = 3'b111;
        expect_box(0, 1'b1, 3'b001, 1'b0);
        expect_box(1, 1'b1, 3'b011, 1'b0);
        expect_box(2, 1'b1, 3'b111, 1'b0);
        expect_idle(5);

        // game off forces all targets hidden
        game = 1'b0;
        expect_box(0, 1'b0, 3'b110, 1'b0);
        expect_box(1, 1'b0, 3'b100, 1'b0);
        expect_box(2, 1'b0, 3'b000, 1'b0);
        expect_idle(5);

        // reset during pixel 20 of slot 1
        game = 1'b1;
        mole = 3'b000;
        do_reset;
        mole = 3'b010;
        begin
            int n = 0;
            while (!vga_plot && n < 20) begin
                step;
                n++;
            end
            check_eq("slot1_latency", n, 1);
        end
        repeat (20) step;
        check_eq("pixel20", {vga_x, vga_y, vga_plot}, {8'd13, 7'd35, 1'b1});
        resetn = 1'b0;
        step;
        check_eq("mid_reset", {vga_plot, busy, drawn}, 5'd0);
        resetn = 1'b1;
        expect_box(1, 1'b1, 3'b010, 1'b0);

        // round-robin continues after slot 1: slot 2 before slot 0
        mole = 3'b111;
        expect_box(2, 1'b1, 3'b110, 1'b0);
        expect_box(0, 1'b1, 3'b111, 1'b0);
        expect_idle(10);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
